// File: rtl/send_data_fsm_pkg.sv
// Shared encodings and frame constants for the UART telemetry sequencer.
package send_data_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam int         FRAME_BYTES = 5;
  localparam logic [2:0] LAST_IDX    = 3'(FRAME_BYTES - 1);
  localparam int         FLAG_OVER   = 0;
  localparam int         FLAG_UNDER  = 1;
  localparam logic [7:0] DEF_HEADER  = 8'hAA;
endpackage

// File: rtl/send_data_fsm_gap_timer.sv
// Loadable down-counter timing the idle gap between frames.
module gap_timer #(
  parameter int GAP_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);
  localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_cnt <= '0;
    else if (i_load)                 r_cnt <= W'(GAP_CYCLES - 1);
    else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/send_data_fsm.sv
// Streams 5-byte telemetry frames (header, sample, flags, checksum) to the UART TX.
import send_data_fsm_pkg::*;

module send_data_fsm #(
  parameter int         DATA_W     = 16,
  parameter int         GAP_CYCLES = 1000000,
  parameter logic [7:0] HEADER     = DEF_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_send,
  input  logic              dis_send,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] th_upper,
  input  logic [DATA_W-1:0] th_lower,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              streaming,
  output logic              alarm,
  output logic              frame_done
);
  state_t            r_state;
  logic [DATA_W-1:0] r_snap;
  logic [1:0]        r_flags;
  logic [7:0]        r_chk;
  logic [2:0]        r_idx;
  logic              r_run;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_alarm;
  logic              r_frame_done;

  logic [1:0] w_flags;
  logic [7:0] w_next_byte;
  logic [2:0] w_next_idx;
  logic       w_last_done;
  logic       w_gap_zero;

  // Flags are computed from the live inputs in LATCH, i.e. from the snapshot values.
  always_comb begin
    w_flags             = '0;
    w_flags[FLAG_OVER]  = sample > th_upper;
    w_flags[FLAG_UNDER] = sample < th_lower;
  end

  assign w_next_idx = r_idx + 3'd1;

  always_comb begin
    w_next_byte = HEADER;
    case (w_next_idx)
      3'd1:    w_next_byte = r_snap[15:8];
      3'd2:    w_next_byte = r_snap[7:0];
      3'd3:    w_next_byte = {6'b0, r_flags};
      3'd4:    w_next_byte = r_chk;
      default: w_next_byte = HEADER;
    endcase
  end

  assign w_last_done = (r_state == WAIT_DONE) && !tx_busy && (r_idx == LAST_IDX);

  gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_last_done),
    .i_en   (r_state == GAP),
    .o_zero (w_gap_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_snap       <= '0;
      r_flags      <= '0;
      r_chk        <= '0;
      r_idx        <= '0;
      r_run        <= 1'b0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_alarm      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      if (dis_send)     r_run <= 1'b0;
      else if (en_send) r_run <= 1'b1;

      case (r_state)
        IDLE: if (r_run) r_state <= LATCH;
        LATCH: begin
          r_snap     <= sample;
          r_flags    <= w_flags;
          r_chk      <= HEADER ^ sample[15:8] ^ sample[7:0] ^ {6'b0, w_flags};
          r_alarm    <= |w_flags;
          r_idx      <= '0;
          r_tx_data  <= HEADER;
          r_tx_start <= 1'b1;
          r_state    <= START;
        end
        START: r_state <= WAIT_ACK;
        WAIT_ACK: if (tx_busy) r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (r_idx != LAST_IDX) begin
              r_idx      <= w_next_idx;
              r_tx_data  <= w_next_byte;
              r_tx_start <= 1'b1;
              r_state    <= START;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= r_run ? GAP : IDLE;
            end
          end
        end
        GAP: if (w_gap_zero) r_state <= r_run ? LATCH : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign streaming  = r_run;
  assign alarm      = r_alarm;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_send_data_fsm.sv
// Scoreboard bench for send_data_fsm with a 3-cycle-busy UART TX model.
module tb_send_data_fsm;
  localparam int GAP = 4;

  logic        clk = 1'b0, reset = 1'b0, en_send = 1'b0, dis_send = 1'b0, tx_busy = 1'b0;
  logic [15:0] sample = '0, th_upper = 16'h1000, th_lower = 16'h0800;
  logic [7:0]  tx_data;
  logic        tx_start, streaming, alarm, frame_done;

  always #5 clk = ~clk;

  send_data_fsm #(.DATA_W(16), .GAP_CYCLES(GAP), .HEADER(8'hAA)) dut (
    .clk(clk), .reset(reset), .en_send(en_send), .dis_send(dis_send),
    .sample(sample), .th_upper(th_upper), .th_lower(th_lower), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .streaming(streaming),
    .alarm(alarm), .frame_done(frame_done)
  );

  int tests = 0, fails = 0;
  int cyc = 0, n_start = 0, n_done = 0, busy_cnt = 0, last_start_cyc = 0, last_done_cyc = 0;
  logic alarm_at_done = 1'b0;
  logic [7:0] exp_q[$], obs_q[$];

  // UART model and monitor: busy for 3 cycles after each start, bytes captured in order.
  always @(negedge clk) begin
    cyc++;
    if (tx_start === 1'b1) begin
      obs_q.push_back(tx_data);
      n_start++;
      last_start_cyc = cyc;
      busy_cnt = 3;
      tx_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      tx_busy = (busy_cnt != 0);
    end
    if (frame_done === 1'b1) begin
      n_done++;
      last_done_cyc = cyc;
      alarm_at_done = alarm;
    end
  end

  function automatic void push_frame(input logic [15:0] s, input logic [15:0] up, input logic [15:0] lo);
    logic [7:0] b [5];
    b[0] = 8'hAA;
    b[1] = s[15:8];
    b[2] = s[7:0];
    b[3] = {6'b0, (s < lo), (s > up)};
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    for (int i = 0; i < 5; i++) exp_q.push_back(b[i]);
  endfunction

  task automatic wait_obs(input int n, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < 400) begin @(negedge clk); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_done(input int n, output bit ok);
    int k = 0;
    while (n_done < n && k < 400) begin @(negedge clk); k++; end
    ok = (n_done >= n);
  endtask

  task automatic pulse_en();
    @(negedge clk) en_send = 1'b1;
    @(negedge clk) en_send = 1'b0;
  endtask

  task automatic pulse_dis();
    @(negedge clk) dis_send = 1'b1;
    @(negedge clk) dis_send = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({tx_data, tx_start, streaming, alarm, frame_done} !== 12'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %03h want 000", {tx_data, tx_start, streaming, alarm, frame_done});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_over();
    bit ok;
    logic [7:0] e, o;
    sample = 16'h1234;
    push_frame(16'h1234, 16'h1000, 16'h0800);
    pulse_en();
    @(negedge clk);
    tests++;
    if (tx_start !== 1'b0) begin fails++; $display("FAIL latency_early: tx_start=%b want 0", tx_start); end
    @(negedge clk);
    tests++;
    if (tx_start !== 1'b1) begin fails++; $display("FAIL latency_start: tx_start=%b want 1", tx_start); end
    tests++;
    if (streaming !== 1'b1) begin fails++; $display("FAIL streaming_set: got %b want 1", streaming); end
    wait_obs(1, ok);
    sample = 16'h0500;  // next frame's snapshot; must not disturb this one
    push_frame(16'h0500, 16'h1000, 16'h0800);
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame1_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame1_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(1, ok);
    tests++;
    if (n_done !== 1) begin fails++; $display("FAIL frame1_done: got %0d pulses want 1", n_done); end
    tests++;
    if (alarm_at_done !== 1'b1) begin fails++; $display("FAIL frame1_alarm: got %b want 1", alarm_at_done); end
    wait_obs(1, ok);
    tests++;
    if (!ok || (last_start_cyc - last_done_cyc) != GAP + 1) begin
      fails++; $display("FAIL gap_len: got %0d cycles want %0d", last_start_cyc - last_done_cyc, GAP + 1);
    end
  endtask

  task automatic test_frame_under();
    bit ok;
    logic [7:0] e, o;
    sample = 16'h0900;
    push_frame(16'h0900, 16'h1000, 16'h0800);
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame2_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame2_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(2, ok);
    tests++;
    if (!ok || alarm_at_done !== 1'b1) begin fails++; $display("FAIL frame2_alarm: got %b want 1", alarm_at_done); end
  endtask

  task automatic test_frame_ok();
    bit ok;
    logic [7:0] e, o;
    wait_obs(1, ok);
    push_frame(16'h0900, 16'h1000, 16'h0800);
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame3_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame3_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(3, ok);
    tests++;
    if (!ok || alarm_at_done !== 1'b0) begin fails++; $display("FAIL frame3_alarm: got %b want 0", alarm_at_done); end
  endtask

  task automatic test_dis_mid_frame();
    bit ok;
    int s0;
    logic [7:0] e, o;
    wait_obs(3, ok);
    pulse_dis();
    tests++;
    if (streaming !== 1'b0) begin fails++; $display("FAIL dis_streaming: got %b want 0", streaming); end
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame4_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame4_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame4_done: got %0d pulses want 4", n_done); end
    s0 = n_start;
    repeat (40) @(negedge clk);
    tests++;
    if (n_start != s0) begin fails++; $display("FAIL dis_no_restart: got %0d starts want %0d", n_start, s0); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int nd, ns;
    logic [7:0] e, o;
    sample = 16'h1234;
    pulse_en();
    wait_obs(2, ok);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({tx_data, tx_start, streaming, alarm, frame_done} !== 12'h0) begin
      fails++;
      $display("FAIL async_reset: got %03h want 000", {tx_data, tx_start, streaming, alarm, frame_done});
    end
    nd = n_done;
    obs_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ns = n_start;
    repeat (10) @(negedge clk);
    tests++;
    if (n_done != nd || n_start != ns) begin
      fails++; $display("FAIL reset_abort: done %0d starts %0d want %0d %0d", n_done, n_start, nd, ns);
    end
    sample = 16'h0900;
    push_frame(16'h0900, 16'h1000, 16'h0800);
    pulse_en();
    wait_obs(1, ok);
    pulse_dis();
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame5_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame5_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(nd + 1, ok);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_en_dis_collision();
    bit ok;
    int s0, nd;
    logic [7:0] e, o;
    s0 = n_start;
    @(negedge clk) begin en_send = 1'b1; dis_send = 1'b1; end
    @(negedge clk) begin en_send = 1'b0; dis_send = 1'b0; end
    repeat (20) @(negedge clk);
    tests++;
    if (streaming !== 1'b0 || n_start != s0) begin
      fails++; $display("FAIL en_dis_same: streaming %b starts %0d want 0 %0d", streaming, n_start, s0);
    end
    nd = n_done;
    sample = 16'h0500;
    push_frame(16'h0500, 16'h1000, 16'h0800);
    pulse_en();
    wait_obs(1, ok);
    pulse_en();  // already streaming: must not restart the frame
    wait_obs(3, ok);
    pulse_dis();
    wait_obs(5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL frame6_timeout: got %0d bytes want 5", obs_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests++; e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin fails++; $display("FAIL frame6_byte%0d: got %02h want %02h", i, o, e); end
    end
    wait_done(nd + 1, ok);
    repeat (40) @(negedge clk);
    tests++;
    if (n_start != s0 + 5 || obs_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL double_en: starts %0d want %0d, extra bytes %0d", n_start - s0, 5, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_over();
    test_frame_under();
    test_frame_ok();
    test_dis_mid_frame();
    test_reset_mid_frame();
    test_en_dis_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/send_data_fsm.md
Name: send_data_fsm

Overview:
Transmit-side sequencer for the UART link. Once the command controller pulses en_send, this block streams telemetry frames perpetually: it snapshots the temperature sample and both thresholds, then serialises a 5-byte frame through the UART TX byte interface using a start/busy handshake. Consecutive frames are separated by a programmable idle gap. It sits between the command controller, the threshold registers, the sensor sample register and the UART TX.

Parameters:
DATA_W, 16, width of sample and threshold words; frame format is fixed for 16.
GAP_CYCLES, 1000000, idle clocks between the end of one frame and the next snapshot; must be at least 1.
HEADER, 8'hAA, first byte of every frame.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous active-low reset; 0 resets the block.
en_send  input  1  one-cycle pulse from the command controller; starts streaming.
dis_send  input  1  one-cycle pulse; stops streaming after the current frame (tie 0 if unused).
sample  input  DATA_W  current temperature sample.
th_upper  input  DATA_W  upper threshold register.
th_lower  input  DATA_W  lower threshold register.
tx_busy  input  1  UART TX is shifting a byte.
tx_data  output  8  byte to transmit.
tx_start  output  1  one-cycle request to send tx_data.
streaming  output  1  run flag.
alarm  output  1  OR of the flags of the last snapshot.
frame_done  output  1  one-cycle pulse when the last byte of a frame completes.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; tx_data=0, tx_start=0, streaming=0, alarm=0, frame_done=0; byte index and gap counter cleared. Reset mid-frame aborts the frame immediately, with no completion pulse.
- All outputs are registered.
- Run flag: set by en_send and cleared by dis_send. If both arrive in the same cycle, dis_send wins. en_send while already streaming has no effect and does not restart the frame.
- Frame bytes, in order:
  - byte 0: HEADER
  - byte 1: snap_sample[15:8]
  - byte 2: snap_sample[7:0]
  - byte 3: FLAGS = {6'b0, under, over}
  - byte 4: CHK = XOR of bytes 0 to 3
- Flags use unsigned compares on snapshot values: over = snap_sample > th_upper; under = snap_sample < th_lower. Both may be 1 if th_lower > th_upper.
- States:
  - IDLE: wait for run=1, then go to LATCH.
  - LATCH: capture sample, th_upper and th_lower; compute flags and CHK; update alarm; byte index = 0; go to START.
  - START: tx_start=1 for exactly one cycle with tx_data valid; go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. If byte index < 4, increment it and go to START. If byte index = 4, pulse frame_done; go to GAP if run=1, otherwise go to IDLE.
  - GAP: load GAP_CYCLES-1 and count down to 0. At 0, go to LATCH if run=1, otherwise go to IDLE.
- tx_data stays stable from START until tx_busy falls in WAIT_DONE.
- Latency: en_send sampled at edge k puts the block in LATCH after edge k+1; tx_start is high in the cycle after edge k+2.
- dis_send mid-frame: the frame always completes, so the link never carries partial frames. The block then returns to IDLE with streaming=0.
- dis_send during GAP: the gap runs to completion, then the block goes to IDLE.
- Input changes after LATCH do not affect the frame in flight.
- tx_busy already high in START: treated as an acknowledge in the following WAIT_ACK cycle.
- tx_busy held low forever in WAIT_ACK: the block waits indefinitely; there is no timeout.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, LATCH, START, WAIT_ACK, WAIT_DONE, GAP)
  - FRAME_BYTES=5
  - flag bit positions FLAG_OVER=0 and FLAG_UNDER=1
  - default HEADER
- One sub-module, gap_timer: a loadable down-counter with load, en and zero outputs, sized $clog2(GAP_CYCLES).

Test Plan:
1. GAP_CYCLES=4; sample=0x1234, th_upper=0x1000, th_lower=0x0800; pulse en_send; UART model asserts busy for 3 cycles per byte -> bytes AA 12 34 01 8D, frame_done once, alarm=1, and the next frame starts after a 4-cycle gap.
2. sample=0x0500, th_upper=0x1000, th_lower=0x0800 -> bytes AA 05 00 02 AD, alarm=1.
3. sample=0x0900, th_upper=0x1000, th_lower=0x0800 -> bytes AA 09 00 00 A3, alarm=0.
4. Pulse dis_send during byte 2 -> bytes 3 and 4 still sent, frame_done pulses, IDLE with streaming=0, and no further tx_start.
5. Drive reset=0 asynchronously mid-WAIT_DONE -> all outputs 0 immediately with no frame_done. After release, a new en_send restarts from HEADER.
6. Pulse en_send and dis_send in the same cycle -> streaming stays 0 and tx_start never asserts. A second en_send while streaming -> frame sequence unchanged.
